// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the queued RAM controller:
//   - default geometry constants (FIFO depth, RAM address and data widths)
//   - state_t, the controller FSM encoding (IDLE, ISSUE, RESP)
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = 5;
    localparam int DEFAULT_DW    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no access in flight
        ISSUE = 2'd1,   // ram_cs is high for exactly this cycle
        RESP  = 2'd2    // read data parked until the consumer takes it
    } state_t;

endpackage : ram_ctrl_pkg

// File: rtl/req_fifo.sv
// ----------------------------------------------------------------------------
// req_fifo
// Synchronous first-in first-out request queue with a combinational head.
//
// Ports:
//   clock    in   single clock, posedge
//   reset_n  in   asynchronous active-low reset; empties the queue
//   i_push   in   write i_wdata at the tail (ignored when full)
//   i_wdata  in   [WIDTH-1:0] entry to enqueue
//   i_pop    in   drop the head entry (ignored when empty)
//   o_rdata  out  [WIDTH-1:0] current head entry
//   o_count  out  [log2(DEPTH):0] number of stored entries
//   o_full   out  o_count == DEPTH
//   o_empty  out  o_count == 0
// ----------------------------------------------------------------------------
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4    // power of two, >= 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // NOTE: storage carries no reset; an entry is only ever read after it
    // has been written, so clearing it would buy nothing but reset fan-out.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
    // on their own.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;   // idle, or push and pop together
            endcase
        end
    end

endmodule : req_fifo

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Queues read/write requests and replays them, strictly in order, onto a RAM
// that samples its registered controls on the falling clock edge.  Writes
// stream at one per cycle; a read holds the RAM idle until its response has
// been accepted.
//
// Ports:
//   clock      in   single clock, posedge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request offered
//   req_ready  out  queue can accept (registered occupancy only)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   [AW-1:0] RAM address
//   req_wdata  in   [DW-1:0] write data
//   rsp_valid  out  read response available
//   rsp_ready  in   consumer accepts the response
//   rsp_rdata  out  [DW-1:0] read data
//   rsp_addr   out  [AW-1:0] address the data came from
//   ram_cs     out  registered RAM chip select
//   ram_we     out  registered RAM write enable
//   ram_addr   out  [AW-1:0] registered RAM address
//   ram_wdata  out  [DW-1:0] registered RAM write data
//   ram_rdata  in   [DW-1:0] RAM data, valid after the falling edge of an
//                   issue cycle
//   busy       out  access in progress or requests queued
//   count      out  [log2(DEPTH):0] queue occupancy
// ----------------------------------------------------------------------------
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_rdata,
    output logic [AW-1:0]            rsp_addr,
    output logic                     ram_cs,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_wdata,
    input  logic [DW-1:0]            ram_rdata,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int EW = 1 + AW + DW;   // queue entry: {we, addr, wdata}

    state_t r_state;
    state_t w_state_nxt;

    logic          r_rst_done;
    logic          r_ram_cs,    w_ram_cs_nxt;
    logic          r_ram_we,    w_ram_we_nxt;
    logic [AW-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [DW-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [AW-1:0] r_rsp_addr,  w_rsp_addr_nxt;

    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_head_we;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_wdata;
    logic [$clog2(DEPTH):0] w_count;

    // Ready depends only on registered occupancy, so a full queue refuses a
    // request even in a cycle where the head is being popped.  r_rst_done
    // keeps ready low until the first edge after reset is released.
    assign req_ready = r_rst_done && !w_full;
    assign w_push    = req_valid && req_ready;

    req_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata ({req_we, req_addr, req_wdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_we    = w_head[EW-1];
    assign w_head_addr  = w_head[DW +: AW];
    assign w_head_wdata = w_head[DW-1:0];

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_ram_cs_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = '0;
        w_ram_wdata_nxt = '0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_addr_nxt  = r_rsp_addr;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_ram_we) begin
                    // The RAM took the write on the falling edge just gone;
                    // back-to-back issue keeps writes at one per cycle.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = ram_rdata;
                    w_rsp_addr_nxt  = r_ram_addr;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Every pop launches the popped entry onto the RAM bus next cycle.
        if (w_pop) begin
            w_ram_cs_nxt    = 1'b1;
            w_ram_we_nxt    = w_head_we;
            w_ram_addr_nxt  = w_head_addr;
            w_ram_wdata_nxt = w_head_wdata;
        end
    end

    // A write whose ram_cs is cleared here before its falling edge is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rst_done  <= 1'b0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_done  <= 1'b1;
            r_ram_cs    <= w_ram_cs_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
        end
    end

    assign ram_cs    = r_ram_cs;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_addr  = r_rsp_addr;
    assign count     = w_count;
    assign busy      = (r_state != IDLE) || (w_count != '0);

endmodule : ram_ctrl

// File: tb/tb_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctrl
// Directed bench for ram_ctrl attached to a 32x32 RAM that samples its
// controls on the falling clock edge.  Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ram_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_addr;
    logic        ram_cs;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic [2:0]  count;

    logic [31:0] mem [32];
    int          n_access;
    int          n_checks;
    int          n_fail;
    int          access_snap;

    ram_ctrl #(
        .DEPTH (4),
        .AW    (5),
        .DW    (32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Falling-edge RAM model.
    always @(negedge clock) begin
        if (ram_cs) begin
            n_access = n_access + 1;
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata     = mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_access  = 0;
        ram_rdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        put(1'b0, 1'b0, 5'd0, 32'd0);

        // ---------------- reset state ----------------
        step();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_count",     count,     3'd0);
        check("rst_ram_cs",    ram_cs,    1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        step();
        reset_n = 1'b1;
        check("rel_ready_low", req_ready, 1'b0);
        step();
        check("rel_ready_high", req_ready, 1'b1);

        // ---------------- write @3 then read @3 ----------------
        rsp_ready = 1'b1;
        put(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        step();
        check("t1_count_after_wr", count, 3'd1);
        put(1'b1, 1'b0, 5'd3, 32'd0);
        step();                                      // read accepted here
        check("t1_wr_cs",    ram_cs,    1'b1);
        check("t1_wr_we",    ram_we,    1'b1);
        check("t1_wr_addr",  ram_addr,  5'd3);
        check("t1_wr_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("t1_count",    count,     3'd1);
        put(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        check("t1_rd_cs",    ram_cs,    1'b1);
        check("t1_rd_we",    ram_we,    1'b0);
        check("t1_rsp_early", rsp_valid, 1'b0);
        step();                                      // two edges after acceptance
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("t1_rsp_addr",  rsp_addr,  5'd3);
        check("t1_cs_low",    ram_cs,    1'b0);
        step();
        check("t1_rsp_done",  rsp_valid, 1'b0);
        check("t1_busy",      busy,      1'b0);

        // ---------------- four back-to-back writes ----------------
        put(1'b1, 1'b1, 5'd0, 32'hA0);
        step();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) put(1'b1, 1'b1, 5'(i), 32'hA0 + 32'(i));
            else       put(1'b0, 1'b0, 5'd0, 32'd0);
            step();
            check("t2_cs",    ram_cs,    1'b1);
            check("t2_we",    ram_we,    1'b1);
            check("t2_addr",  ram_addr,  5'(i - 1));
            check("t2_wdata", ram_wdata, 32'hA0 + 32'(i - 1));
            check("t2_count", count,     (i < 4) ? 3'd1 : 3'd0);
            check("t2_ready", req_ready, 1'b1);
        end
        step();
        check("t2_cs_end", ram_cs, 1'b0);
        check("t2_mem3",   mem[3], 32'hA3);

        // ---------------- read @5 held, queue fills, full + pop ----------------
        rsp_ready = 1'b0;
        put(1'b1, 1'b0, 5'd5, 32'd0);
        step();                                      // read accepted
        check("t3_count0", count,  3'd1);
        check("t3_cs0",    ram_cs, 1'b0);
        put(1'b1, 1'b1, 5'd8, 32'h88);
        step();
        check("t3_rd_cs",   ram_cs,   1'b1);
        check("t3_rd_we",   ram_we,   1'b0);
        check("t3_rd_addr", ram_addr, 5'd5);
        put(1'b1, 1'b1, 5'd9, 32'h99);
        step();
        check("t3_count2", count, 3'd2);
        put(1'b1, 1'b1, 5'd10, 32'hAA);
        for (int c = 0; c < 6; c++) begin
            check("t3_hold_valid", rsp_valid, 1'b1);
            check("t3_hold_rdata", rsp_rdata, 32'h1000_0005);
            check("t3_hold_addr",  rsp_addr,  5'd5);
            check("t3_hold_cs",    ram_cs,    1'b0);
            step();
            if (c == 0) put(1'b1, 1'b1, 5'd11, 32'hBB);
            if (c == 1) put(1'b1, 1'b1, 5'd12, 32'hC12);   // offered into a full queue
            if (c >= 1) begin
                check("t3_full_count", count,     3'd4);
                check("t3_full_ready", req_ready, 1'b0);
            end
        end
        rsp_ready = 1'b1;
        step();                                      // handshake + pop, 5th refused
        check("t3_hs_valid", rsp_valid, 1'b0);
        check("t3_hs_count", count,     3'd3);
        check("t3_hs_cs",    ram_cs,    1'b1);
        check("t3_hs_addr",  ram_addr,  5'd8);
        check("t3_hs_ready", req_ready, 1'b1);
        step();                                      // 5th accepted alongside a pop
        check("t3_acc_count", count,    3'd3);
        check("t3_acc_addr",  ram_addr, 5'd9);
        put(1'b0, 1'b0, 5'd0, 32'd0);
        for (int a = 10; a <= 12; a++) begin
            step();
            check("t3_drain_addr",  ram_addr, 5'(a));
            check("t3_drain_count", count,    3'(12 - a));
        end
        check("t3_drain_wdata", ram_wdata, 32'hC12);
        step();
        check("t3_idle_cs",   ram_cs, 1'b0);
        check("t3_idle_busy", busy,   1'b0);
        check("t3_mem12",     mem[12], 32'hC12);

        // ---------------- reset mid-RESP with 3 queued ----------------
        rsp_ready = 1'b0;
        put(1'b1, 1'b0, 5'd1, 32'd0);
        step();
        put(1'b1, 1'b1, 5'd20, 32'h2020);
        step();
        put(1'b1, 1'b1, 5'd21, 32'h2121);
        step();
        put(1'b1, 1'b1, 5'd22, 32'h2222);
        step();
        put(1'b0, 1'b0, 5'd0, 32'd0);
        check("t4_pre_valid", rsp_valid, 1'b1);
        check("t4_pre_rdata", rsp_rdata, 32'hA1);
        check("t4_pre_count", count,     3'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t4_rst_valid", rsp_valid, 1'b0);
        check("t4_rst_rdata", rsp_rdata, 32'd0);
        check("t4_rst_count", count,     3'd0);
        check("t4_rst_cs",    ram_cs,    1'b0);
        check("t4_rst_busy",  busy,      1'b0);
        check("t4_rst_ready", req_ready, 1'b0);
        access_snap = n_access;
        step();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        check("t4_rel_ready_low", req_ready, 1'b0);
        step();
        check("t4_rel_ready_high", req_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_post_cs",   ram_cs, 1'b0);
            check("t4_post_busy", busy,   1'b0);
        end
        check("t4_no_access", n_access, access_snap);
        check("t4_mem20",     mem[20],  32'h1000_0014);

        // ---------------- top address ----------------
        put(1'b1, 1'b1, 5'd31, 32'h11);
        step();
        put(1'b1, 1'b0, 5'd31, 32'd0);
        step();
        check("t5_wr_addr", ram_addr, 5'd31);
        put(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        check("t5_rd_addr", ram_addr, 5'd31);
        step();
        check("t5_rsp_valid", rsp_valid, 1'b1);
        check("t5_rsp_rdata", rsp_rdata, 32'h11);
        check("t5_rsp_addr",  rsp_addr,  5'd31);
        step();
        check("t5_rsp_done", rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_ctrl
